// File: rtl/formula_pipe_flow_ctrl.sv
// formula_pipe_flow_ctrl: credit-based valid/ready shell around a fixed-latency, non-stalling compute pipe.
// Results are captured in a FIFO whose space is reserved by credits at issue time.
module formula_pipe_flow_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_c,
    output logic             pipe_arg_vld,
    output logic [WIDTH-1:0] pipe_a,
    output logic [WIDTH-1:0] pipe_b,
    output logic [WIDTH-1:0] pipe_c,
    input  logic             pipe_res_vld,
    input  logic [WIDTH-1:0] pipe_res,
    output logic             dn_vld,
    input  logic             dn_rdy,
    output logic [WIDTH-1:0] dn_res,
    output logic             ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [CW-1:0]    credits_q, credits_d, count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             ovf_q, issue, pop, push, full;
    assign full         = count_q == CW'(DEPTH);
    assign up_rdy       = !rst && credits_q != '0;
    assign issue        = up_vld && up_rdy;
    assign pipe_arg_vld = issue;
    assign pipe_a       = issue ? up_a : a_q;
    assign pipe_b       = issue ? up_b : b_q;
    assign pipe_c       = issue ? up_c : c_q;
    assign dn_vld       = !rst && count_q != '0;
    assign dn_res       = mem_q[rd_ptr_q];
    assign pop          = dn_vld && dn_rdy;
    assign push         = !rst && pipe_res_vld && !full;
    assign ovf_err      = ovf_q;
    always_comb begin
        credits_d = credits_q - CW'(issue) + CW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(DEPTH);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pipe_res_vld && full) ovf_q <= 1'b1;
        end
    end
    // Storage and argument hold registers carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pipe_res;
        if (issue) begin
            a_q <= up_a;
            b_q <= up_b;
            c_q <= up_c;
        end
    end
endmodule

// File: tb/tb_formula_pipe_flow_ctrl.sv
// tb_formula_pipe_flow_ctrl: random and directed checks of the flow-control shell
// around a 4-cycle isqrt-sum pipe model, scored against an issue-order queue.
module tb_formula_pipe_flow_ctrl;
    localparam int W = 32;
    localparam int D = 16;
    localparam int L = 4;
    logic clk = 0, rst = 1, up_vld = 0, dn_rdy = 0, inj = 0;
    logic [W-1:0] up_a = 0, up_b = 0, up_c = 0;
    logic up_rdy, pipe_arg_vld, pipe_res_vld, dn_vld, ovf_err;
    logic [W-1:0] pipe_a, pipe_b, pipe_c, pipe_res, dn_res;
    logic sv [L];
    logic [W-1:0] sr [L];
    int vec = 0, err = 0, ecount = 0, nissued = 0;
    logic [W-1:0] q [$];
    int tq [$];
    logic exp_ovf = 0, have_last = 0;
    logic [W-1:0] last_a;

    formula_pipe_flow_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
        .up_a(up_a), .up_b(up_b), .up_c(up_c),
        .pipe_arg_vld(pipe_arg_vld), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
        .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
        .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_res(dn_res), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        logic [63:0] r = 0;
        for (int b = 15; b >= 0; b--) begin
            logic [63:0] t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] f(input logic [W-1:0] a, b, c);
        return isqrt(a) + isqrt(b) + isqrt(c);
    endfunction

    // Pipe model: fixed latency, flushed by reset; inj forces a spurious result.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) sv[i] <= 1'b0;
        end else begin
            sv[0] <= pipe_arg_vld;
            sr[0] <= f(pipe_a, pipe_b, pipe_c);
            for (int i = 1; i < L; i++) begin
                sv[i] <= sv[i-1];
                sr[i] <= sr[i-1];
            end
        end
    end
    assign pipe_res_vld = sv[L-1] | inj;
    assign pipe_res     = inj ? 32'hDEAD_BEEF : sr[L-1];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, ecount);
        end
    endtask

    task automatic tick();
        logic iss, pp, ev;
        #1;
        iss = up_vld && up_rdy;
        pp  = dn_vld && dn_rdy;
        ev  = !rst && q.size() > 0 && ecount >= tq[0] + L;
        chk("up_rdy", {31'd0, up_rdy}, {31'd0, !rst && q.size() < D});
        chk("dn_vld", {31'd0, dn_vld}, {31'd0, ev});
        chk("pipe_arg_vld", {31'd0, pipe_arg_vld}, {31'd0, !rst && up_vld && q.size() < D});
        chk("ovf_err", {31'd0, ovf_err}, {31'd0, exp_ovf});
        if (iss) chk("pipe_a_pass", pipe_a, up_a);
        else if (have_last) chk("pipe_a_hold", pipe_a, last_a);
        if (pp && q.size() > 0) begin
            chk("dn_res", dn_res, q[0]);
            void'(q.pop_front());
            void'(tq.pop_front());
        end
        if (iss) begin
            q.push_back(f(up_a, up_b, up_c));
            tq.push_back(ecount + 1);
            last_a = up_a;
            have_last = 1;
            nissued++;
        end
        @(posedge clk);
        ecount++;
        if (rst) begin
            q.delete();
            tq.delete();
            exp_ovf = 0;
        end
        #1;
    endtask

    task automatic rnd_args();
        up_a = $urandom;
        up_b = $urandom;
        up_c = $urandom;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        up_vld = 0;
        dn_rdy = 1;
        while (q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        int n0, n;
        // Reset and idle outputs
        @(posedge clk);
        #1;
        tick();
        rst = 0;
        #1;
        chk("rst_up_rdy", {31'd0, up_rdy}, 1);
        chk("rst_dn_vld", {31'd0, dn_vld}, 0);
        chk("rst_ovf", {31'd0, ovf_err}, 0);
        // Single op: isqrt(4)+isqrt(9)+isqrt(16) = 9
        dn_rdy = 1;
        up_vld = 1; up_a = 4; up_b = 9; up_c = 16;
        tick();
        up_vld = 0;
        for (int i = 0; i < L - 1; i++) tick();
        chk("single_not_early", {31'd0, dn_vld}, 0);
        tick();
        chk("single_vld", {31'd0, dn_vld}, 1);
        chk("single_res", dn_res, 9);
        tick();
        chk("single_gone", {31'd0, dn_vld}, 0);
        // Streaming 100 back-to-back
        n0 = nissued;
        up_vld = 1;
        for (int i = 0; i < 100; i++) begin
            rnd_args();
            tick();
        end
        chk("stream_issued", nissued - n0, 100);
        drain(50);
        // Backpressure: exactly D issues accepted
        dn_rdy = 0;
        up_vld = 1;
        n0 = nissued;
        for (int i = 0; i < 24; i++) begin
            rnd_args();
            tick();
        end
        chk("bp_issued", nissued - n0, D);
        up_vld = 0;
        dn_rdy = 1;
        tick();
        chk("bp_rdy_back", {31'd0, up_rdy}, 1);
        drain(40);
        // Random valid/ready with pointer wrap
        n0 = nissued;
        n = 0;
        while (nissued - n0 < 40 && n < 600) begin
            rnd_args();
            up_vld = $urandom_range(0, 1);
            dn_rdy = $urandom_range(0, 1);
            tick();
            n++;
        end
        chk("wrap_issued", nissued - n0, 40);
        drain(60);
        // Reset with 5 queued, 3 in flight
        dn_rdy = 0;
        up_vld = 1;
        for (int i = 0; i < 8; i++) begin
            rnd_args();
            tick();
        end
        up_vld = 0;
        tick();
        chk("mid_queued", {31'd0, dn_vld}, 1);
        rst = 1;
        tick();
        rst = 0;
        dn_rdy = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_rdy", {31'd0, up_rdy}, 1);
        chk("post_rst_no_stale", {31'd0, dn_vld}, 0);
        // Overflow guard: fill, inject a spurious result, drain intact
        dn_rdy = 0;
        up_vld = 1;
        for (int i = 0; i < D; i++) begin
            rnd_args();
            tick();
        end
        up_vld = 0;
        for (int i = 0; i < L + 1; i++) tick();
        inj = 1;
        tick();
        inj = 0;
        exp_ovf = 1;
        chk("ovf_set", {31'd0, ovf_err}, 1);
        drain(40);
        for (int i = 0; i < 3; i++) tick();
        chk("ovf_sticky", {31'd0, ovf_err}, 1);
        rst = 1;
        tick();
        rst = 0;
        tick();
        chk("ovf_cleared", {31'd0, ovf_err}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
